// File: rtl/curve_pkg.sv
// Shared types and elaboration-time helpers for the curve delay mapper:
// the curve mode encoding and the constant functions that build the transfer tables.
package curve_pkg;

    typedef enum logic [1:0] {
        CURVE_LIN   = 2'd0,
        CURVE_QUAD  = 2'd1,
        CURVE_IQUAD = 2'd2,
        CURVE_MUTE  = 2'd3
    } curve_mode_e;

    // Width of the tap select bus; a single-stage line still gets one bit.
    function automatic int tap_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned full_scale(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned lin_point(input int unsigned x, input int in_w,
                                              input int out_w);
        longint unsigned xl;
        longint unsigned imax;
        longint unsigned omax;
        xl   = 64'(x);
        imax = 64'(full_scale(in_w));
        omax = 64'(full_scale(out_w));
        return 32'((xl * omax) / imax);
    endfunction

    function automatic int unsigned quad_point(input int unsigned x, input int in_w,
                                               input int out_w);
        longint unsigned xl;
        longint unsigned imax;
        longint unsigned omax;
        xl   = 64'(x);
        imax = 64'(full_scale(in_w));
        omax = 64'(full_scale(out_w));
        return 32'((xl * xl * omax) / (imax * imax));
    endfunction

    // Mirror of the quadratic curve about both axes, giving the log-like shape.
    function automatic int unsigned iquad_point(input int unsigned x, input int in_w,
                                                input int out_w);
        return full_scale(out_w) - quad_point(full_scale(in_w) - x, in_w, out_w);
    endfunction

endpackage

// File: rtl/curve_delay_mapper_if.sv
// Sample/control bundle between the sample source, the curve delay mapper and the
// amplitude path.
interface curve_delay_mapper_if
    import curve_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 7,
    parameter int DEPTH = 9
);
    localparam int TAP_W = tap_width(DEPTH);

    // Handshake: ready is a one-cycle strobe qualifying in (there is no back-pressure,
    // every strobe taken while en=1 and flush=0 is accepted); out_valid is a one-cycle
    // pulse marking the cycle in which exp_out carries a freshly mapped, primed tap.
    logic              en;
    logic              ready;
    logic              flush;
    logic [IN_W-1:0]   in;
    logic [1:0]        mode;
    logic [TAP_W-1:0]  tap_sel;
    logic [OUT_W-1:0]  exp_out;
    logic              out_valid;

    modport master (
        output en, ready, flush, in, mode, tap_sel,
        input  exp_out, out_valid
    );

    modport slave (
        input  en, ready, flush, in, mode, tap_sel,
        output exp_out, out_valid
    );

endinterface

// File: rtl/curve_lut.sv
// Combinational transfer-curve lookup: three constant tables of 2^IN_W entries
// selected by mode, with mute forcing zero.
module curve_lut
    import curve_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 7
) (
    input  curve_mode_e        mode,
    input  logic [IN_W-1:0]    x,
    output logic [OUT_W-1:0]   y
);
    localparam int ENTRIES = 2 ** IN_W;

    logic [OUT_W-1:0] lin_t   [ENTRIES];
    logic [OUT_W-1:0] quad_t  [ENTRIES];
    logic [OUT_W-1:0] iquad_t [ENTRIES];

    // Every entry is folded to a constant at elaboration; no arithmetic survives.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_tab
        localparam logic [OUT_W-1:0] LIN_V   = OUT_W'(lin_point(32'(i), IN_W, OUT_W));
        localparam logic [OUT_W-1:0] QUAD_V  = OUT_W'(quad_point(32'(i), IN_W, OUT_W));
        localparam logic [OUT_W-1:0] IQUAD_V = OUT_W'(iquad_point(32'(i), IN_W, OUT_W));
        assign lin_t[i]   = LIN_V;
        assign quad_t[i]  = QUAD_V;
        assign iquad_t[i] = IQUAD_V;
    end

    always_comb begin
        y = '0;
        unique case (mode)
            CURVE_LIN:   y = lin_t[x];
            CURVE_QUAD:  y = quad_t[x];
            CURVE_IQUAD: y = iquad_t[x];
            CURVE_MUTE:  y = '0;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/curve_delay_mapper.sv
// Strobed delay line with run-time tap select feeding a selectable transfer curve
// into a registered output with a primed-tap valid pulse.
module curve_delay_mapper
    import curve_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 7,
    parameter int DEPTH = 9
) (
    input  logic                  MHz10,
    input  logic                  nrst,
    curve_delay_mapper_if.slave   bus
);
    localparam int TAP_W  = tap_width(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [IN_W-1:0]   stage [DEPTH];
    logic [FILL_W-1:0] fill;
    logic              ready_d;
    logic [OUT_W-1:0]  exp_out_q;
    logic              out_valid_q;

    logic              accept;
    logic [TAP_W-1:0]  tap_eff;
    logic [IN_W-1:0]   tap_x;
    logic              primed;
    curve_mode_e       mode_e;
    logic [OUT_W-1:0]  curve_y;

    assign accept = bus.en & bus.ready & ~bus.flush;
    assign mode_e = curve_mode_e'(bus.mode);

    // Out-of-range taps read the oldest stage, so "primed" then means a full line.
    always_comb begin
        tap_eff = bus.tap_sel;
        if (32'(bus.tap_sel) >= 32'(DEPTH)) begin
            tap_eff = TAP_W'(DEPTH - 1);
        end
    end

    assign tap_x  = stage[tap_eff];
    assign primed = 32'(fill) > 32'(tap_eff);

    // Flush clears even while disabled; a strobe in the same cycle is dropped.
    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (bus.en && bus.ready) begin
            stage[0] <= bus.in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            fill <= '0;
        end else if (bus.flush) begin
            fill <= '0;
        end else if (bus.en && bus.ready && (fill != FILL_W'(DEPTH))) begin
            fill <= fill + FILL_W'(1);
        end
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            ready_d <= 1'b0;
        end else begin
            ready_d <= accept;
        end
    end

    curve_lut #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_lut (
        .mode (mode_e),
        .x    (tap_x),
        .y    (curve_y)
    );

    // The update lands one cycle after the strobe, reading the line as already shifted;
    // mode and tap_sel are therefore taken at this edge, not at the strobe edge.
    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            exp_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (!bus.en) begin
            exp_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (ready_d) begin
            exp_out_q   <= curve_y;
            out_valid_q <= primed;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.exp_out   = exp_out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_curve_delay_mapper.sv
// Bench for curve_delay_mapper: directed scenarios plus random traffic, checked by a
// queue-based reference of the delay line and a decoupled output monitor.
module tb_curve_delay_mapper;
    import curve_pkg::*;

    localparam int IN_W  = 5;
    localparam int OUT_W = 7;
    localparam int DEPTH = 9;
    localparam int TAP_W = tap_width(DEPTH);

    // ---------------- clock / reset ----------------
    logic clk;
    logic nrst;
    bit   started;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    curve_delay_mapper_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    curve_delay_mapper #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .MHz10 (clk),
        .nrst  (nrst),
        .bus   (bus.slave)
    );

    // ---------------- reference model ----------------
    int               n_total;
    int               n_pass;
    logic [IN_W-1:0]  line_q[$];   // index 0 = newest sample
    int               m_fill;
    bit               m_pend;
    logic [OUT_W-1:0] m_out;
    logic [OUT_W-1:0] exp_q[$];

    function automatic int curve_ref(input int m, input int x);
        longint imax;
        longint omax;
        longint xl;
        imax = (64'd1 << IN_W) - 1;
        omax = (64'd1 << OUT_W) - 1;
        xl   = longint'(x);
        case (m)
            0:       return int'(xl * omax / imax);
            1:       return int'(xl * xl * omax / (imax * imax));
            2:       return int'(omax - (imax - xl) * (imax - xl) * omax / (imax * imax));
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear_line();
        line_q = {};
        for (int i = 0; i < DEPTH; i++) line_q.push_back('0);
        m_fill = 0;
    endtask

    // Applies the rules of one active edge to the model, using the inputs just driven.
    task automatic model_edge();
        int te;
        logic [OUT_W-1:0] y;
        te = (int'(bus.tap_sel) >= DEPTH) ? DEPTH - 1 : int'(bus.tap_sel);
        if (!bus.en) begin
            m_out = '0;
        end else if (m_pend) begin
            y = OUT_W'(curve_ref(int'(bus.mode), int'(line_q[te])));
            m_out = y;
            if (m_fill > te) exp_q.push_back(y);
        end
        if (bus.flush) begin
            model_clear_line();
        end else if (bus.en && bus.ready) begin
            line_q.push_front(bus.in);
            void'(line_q.pop_back());
            if (m_fill < DEPTH) m_fill++;
        end
        m_pend = bus.en && bus.ready && !bus.flush;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic e, input logic r, input logic f,
                       input logic [IN_W-1:0] d, input logic [1:0] m,
                       input logic [TAP_W-1:0] t);
        bus.en      = e;
        bus.ready   = r;
        bus.flush   = f;
        bus.in      = d;
        bus.mode    = m;
        bus.tap_sel = t;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Strobe followed by one idle cycle, with mode/tap held across the update edge.
    task automatic strobe(input logic [IN_W-1:0] d, input logic [1:0] m,
                          input logic [TAP_W-1:0] t);
        cyc(1'b1, 1'b1, 1'b0, d, m, t);
        cyc(1'b1, 1'b0, 1'b0, d, m, t);
    endtask

    task automatic do_reset();
        #1;
        nrst = 1'b0;
        model_clear_line();
        m_pend = 1'b0;
        m_out  = '0;
        exp_q  = {};
        #1;
        chk("reset_exp_out", int'(bus.exp_out), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (started) begin
            logic exp_v;
            logic [OUT_W-1:0] e;
            exp_v = (exp_q.size() != 0);
            chk("exp_out_level", int'(bus.exp_out), int'(m_out));
            chk("out_valid", int'(bus.out_valid), int'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                if (bus.out_valid) chk("valid_data", int'(bus.exp_out), int'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    int seq1 [13] = '{3, 8, 16, 31, 30, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        n_total = 0;
        n_pass  = 0;
        started = 1'b0;
        model_clear_line();
        m_pend = 1'b0;
        m_out  = '0;
        nrst        = 1'b0;
        bus.en      = 1'b0;
        bus.ready   = 1'b0;
        bus.flush   = 1'b0;
        bus.in      = '0;
        bus.mode    = 2'd0;
        bus.tap_sel = '0;
        #2;
        chk("por_exp_out", int'(bus.exp_out), 0);
        chk("por_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst    = 1'b1;
        started = 1'b1;

        // Fill to the deepest tap with the quad curve.
        for (int i = 0; i < 13; i++) strobe(IN_W'(seq1[i]), CURVE_QUAD, TAP_W'(8));

        // One strobe per curve at tap 0.
        strobe(IN_W'(16), CURVE_LIN, '0);
        strobe(IN_W'(16), CURVE_QUAD, '0);
        strobe(IN_W'(15), CURVE_IQUAD, '0);
        strobe(IN_W'(16), CURVE_MUTE, '0);

        // Prime, then flush colliding with a strobe.
        for (int i = 0; i < DEPTH; i++) strobe(IN_W'($urandom_range(0, 31)), CURVE_LIN, TAP_W'(3));
        cyc(1'b1, 1'b1, 1'b1, IN_W'(21), CURVE_LIN, TAP_W'(3));
        cyc(1'b1, 1'b0, 1'b0, '0, CURVE_LIN, TAP_W'(3));
        for (int i = 0; i < 5; i++) strobe(IN_W'(i + 7), CURVE_LIN, TAP_W'(3));

        // Disabled for 20 cycles while strobes keep arriving.
        for (int i = 0; i < DEPTH; i++) strobe(IN_W'($urandom_range(0, 31)), CURVE_LIN, TAP_W'(4));
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'(i % 2), 1'b0, IN_W'($urandom_range(0, 31)), CURVE_LIN, TAP_W'(4));
        for (int i = 0; i < 3; i++) strobe(IN_W'($urandom_range(0, 31)), CURVE_LIN, TAP_W'(4));

        // Back-to-back ramp.
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b0, IN_W'(i), CURVE_QUAD, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, CURVE_QUAD, '0);

        // Reset mid-ramp, then refill as at the start.
        for (int i = 0; i < 5; i++) strobe(IN_W'(i * 3), CURVE_QUAD, TAP_W'(8));
        do_reset();
        for (int i = 0; i < 13; i++) strobe(IN_W'(seq1[i]), CURVE_QUAD, TAP_W'(8));

        // Random traffic, including out-of-range taps and stray flushes.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 29) == 0), IN_W'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)), TAP_W'($urandom_range(0, 11)));

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, CURVE_LIN, '0);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/curve_delay_mapper.md
# curve_delay_mapper

Parametrised successor to the fixed 5→7-bit exponential lookup. Delays a strobed sample stream through a DEPTH-stage shift line, selects a run-time tap, and maps the tapped sample through a selectable transfer curve (linear, quadratic "exp", inverse-quadratic "log", mute) into a registered output. Adds a valid pulse, a fill counter and a flush. Sits between the note/envelope sample source and the amplitude/DAC path in the 10 MHz synth domain.

## Interface
- IN_W, 5, input sample width (2..8)
- OUT_W, 7, output width (2..10)
- DEPTH, 9, delay stages (1..16)
- TAP_W, $clog2(DEPTH) (min 1), width of tap_sel (derived, not overridden)
- MHz10  input  1  system clock, rising edge
- nrst  input  1  reset nrst, asynchronous, active-low
- en  input  1  block enable; low freezes the delay line and mutes the output
- ready  input  1  sample strobe; one-cycle pulse per new sample
- flush  input  1  synchronous clear of delay line and fill count
- in  input  IN_W  sample, captured when ready=1
- mode  input  2  curve: 0 linear, 1 quad (exp), 2 inverse quad (log), 3 mute
- tap_sel  input  TAP_W  stage read; 0 = newest
- exp_out  output  OUT_W  registered curve output
- out_valid  output  1  one-cycle pulse when exp_out has been updated with a primed tap

## Operation
- Constants: IMAX = 2^IN_W−1, OMAX = 2^OUT_W−1.
- Delay line: stage[0..DEPTH−1]. On an edge with en=1, ready=1, flush=0: stage[0]<=in, stage[i]<=stage[i−1].
- Fill counter fill (0..DEPTH, saturating): +1 per accepted shift. flush=1: all stages and fill <= 0; flush beats ready in the same cycle, and the sample is dropped.
- ready_d: register = en & ready & ~flush.
- Curves on x = stage[tap_sel]; all integer, floor:
  - linear: x·OMAX/IMAX
  - quad: x²·OMAX/IMAX² (IN_W=5, OUT_W=7: 3→1, 8→8, 16→33, 30→118, 31→127)
  - inverse quad: OMAX − quad(IMAX−x)
  - mute: 0
- Curves are built as elaboration-time constant tables of 2^IN_W entries. No run-time multiply or divide.
- Output register:
  - Edge with en=0: exp_out <= 0, out_valid <= 0.
  - Else if ready_d=1: exp_out <= curve(mode, x); out_valid <= (fill > tap_sel).
  - Else: exp_out holds, out_valid <= 0.
- Unprimed tap (fill ≤ tap_sel) still loads exp_out from the zeroed stage; out_valid stays 0.
- tap_sel ≥ DEPTH is illegal. In that case the block reads stage[DEPTH−1] and out_valid follows fill==DEPTH.
- en=0 holds stages and fill. On re-enable, operation resumes without loss.

## Timing
- Reset values: all stages 0, fill 0, ready_d 0, exp_out 0, out_valid 0.
- A sample accepted at edge E sits in stage[k] after k further accepted strobes.
- exp_out reflects the tapped sample at edge E+1 after the strobe that placed it there; out_valid is high for the cycle E+1→E+2.
- Latency from the strobe to exp_out: 1 cycle for tap_sel=0; otherwise tap_sel further strobes plus 1 cycle.
- mode and tap_sel are sampled at the ready_d edge only. Mid-stream changes affect the next update, never a partial one.
- Back-to-back ready strobes (every cycle) are legal: one shift and one update per cycle.
- nrst assert mid-stream clears everything immediately. The first out_valid after release needs tap_sel+1 new strobes.
- ready with en=0: ignored, no shift. flush with en=0 still clears.

## Structure
- Package curve_pkg holds:
  - the mode enum (CURVE_LIN, CURVE_QUAD, CURVE_IQUAD, CURVE_MUTE)
  - constant functions building the curve tables from IN_W/OUT_W
- Sub-module curve_lut (combinational: mode, x → y) instantiates the three tables. The top module holds the delay line, fill counter, ready_d and output register.

## Test plan
- Reset, then quad, tap_sel=8, DEPTH=9. Strobe 3,8,16,31,30,0,0,0,0. Required: no out_valid for the first 8 strobes; on the 9th, exp_out=1 with out_valid; next four strobes give 8, 33, 127, 118.
- tap_sel=0, input 16, one strobe per mode:
  - linear → 65
  - quad → 33
  - inverse quad with input 15 → 94
  - mute → 0
  - Each update is one cycle after its strobe.
- Primed line with ready and flush in the same cycle. Required: sample dropped, fill=0, and no out_valid until tap_sel+1 new strobes.
- en low for 20 cycles while ready toggles. Required: exp_out=0, no out_valid, stages frozen. After re-enable, the next strobe outputs the sample that was in stage[tap_sel−1] before the pause.
- Back-to-back ready every cycle for 32 cycles, ramp 0..31, quad, tap_sel=0. Required: exp_out follows the table one cycle behind and out_valid is continuously high.
- nrst asserted between strobes mid-ramp. Required: exp_out and out_valid are 0 immediately, and the refill behaves as in the first scenario.
